// File: rtl/screen_pkg.sv
// Shared types and default play-button geometry for the screen sequencer and start screen.
package screen_pkg;

  typedef enum logic [1:0] {
    ST_START     = 2'd0,
    ST_COUNTDOWN = 2'd1,
    ST_PLAY      = 2'd2,
    ST_END       = 2'd3
  } screen_state_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  localparam int PLAY_BTN_X = 380;
  localparam int PLAY_BTN_Y = 500;
  localparam int PLAY_BTN_W = 200;
  localparam int PLAY_BTN_H = 100;

  // Halves every channel; used to dim the game view behind the countdown.
  function automatic rgb_t half_rgb(input rgb_t p);
    rgb_t h;
    h.r = {1'b0, p.r[7:1]};
    h.g = {1'b0, p.g[7:1]};
    h.b = {1'b0, p.b[7:1]};
    return h;
  endfunction

endpackage

// File: rtl/frame_timer.sv
// Frame-tick counter with a runtime limit; pulses done on the tick where count reaches limit-1.
module frame_timer #(
  parameter int W = 8
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         clear,
  input  logic         tick,
  input  logic [W-1:0] limit,
  output logic         done
);

  logic [W-1:0] count;

  assign done = tick && !clear && (count == limit - W'(1));

  // NOTE: reset is sampled inside the clocked block (synchronous); state uses <= only.
  always_ff @(posedge clk_in) begin
    if (rst_in || clear) begin
      count <= '0;
    end else if (tick) begin
      count <= done ? '0 : count + W'(1);
    end
  end

endmodule

// File: rtl/screen_sequencer.sv
// Start / countdown / play / end screen sequencer with registered pixel mux.
// Define CURSOR_SELECT_EN to also accept a click on the play button as a start request.
module screen_sequencer
  import screen_pkg::*;
#(
  parameter int FRAMES_PER_COUNT = 60,
  parameter int COUNT_FROM       = 3,
  parameter int END_HOLD_FRAMES  = 180,
  parameter int BTN_X            = PLAY_BTN_X,
  parameter int BTN_Y            = PLAY_BTN_Y,
  parameter int BTN_W            = PLAY_BTN_W,
  parameter int BTN_H            = PLAY_BTN_H
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  input  logic        start_btn_in,
  input  logic [10:0] cursor_x_in,
  input  logic [9:0]  cursor_y_in,
  input  logic        click_in,
  input  logic        game_over_in,
  input  logic [23:0] start_pixel_in,
  input  logic [23:0] game_pixel_in,
  input  logic [23:0] end_pixel_in,
  output logic [1:0]  state_out,
  output logic [1:0]  countdown_out,
  output logic        game_active_out,
  output logic [23:0] pixel_out
);

  localparam int MAX_FRAMES = (FRAMES_PER_COUNT > END_HOLD_FRAMES) ? FRAMES_PER_COUNT
                                                                   : END_HOLD_FRAMES;
  localparam int CNT_W      = $clog2(MAX_FRAMES + 1);

  screen_state_t state, state_next;
  logic [1:0]    digit, digit_next;
  rgb_t          pixel_q, pixel_next;
  logic          btn_q;
  logic          start_req;
  logic          frame_tick;
  logic          timer_tick, timer_clear, timer_done;
  logic [CNT_W-1:0] timer_limit;

  assign frame_tick = (hcount_in == 11'd0) && (vcount_in == 10'd0);

`ifdef CURSOR_SELECT_EN
  localparam logic [11:0] X_LO = 12'(BTN_X);
  localparam logic [11:0] X_HI = 12'(BTN_X + BTN_W);
  localparam logic [10:0] Y_LO = 11'(BTN_Y);
  localparam logic [10:0] Y_HI = 11'(BTN_Y + BTN_H);

  logic click_q;
  logic on_button;

  assign on_button = ({1'b0, cursor_x_in} >= X_LO) && ({1'b0, cursor_x_in} < X_HI) &&
                     ({1'b0, cursor_y_in} >= Y_LO) && ({1'b0, cursor_y_in} < Y_HI);
  assign start_req = (start_btn_in && !btn_q) || (click_in && !click_q && on_button);

  always_ff @(posedge clk_in) begin
    if (rst_in) click_q <= 1'b0;
    else        click_q <= click_in;
  end
`else
  logic unused_cursor;
  assign unused_cursor = ^{cursor_x_in, cursor_y_in, click_in,
                           32'(BTN_X), 32'(BTN_Y), 32'(BTN_W), 32'(BTN_H)};
  assign start_req = start_btn_in && !btn_q;
`endif

  // Counter only runs in the timed states and is held clear elsewhere, so every entry starts at 0.
  assign timer_tick  = frame_tick && ((state == ST_COUNTDOWN) || (state == ST_END));
  assign timer_clear = (state == ST_START) || (state == ST_PLAY);
  assign timer_limit = (state == ST_END) ? CNT_W'(END_HOLD_FRAMES) : CNT_W'(FRAMES_PER_COUNT);

  frame_timer #(.W(CNT_W)) u_frame_timer (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .clear  (timer_clear),
    .tick   (timer_tick),
    .limit  (timer_limit),
    .done   (timer_done)
  );

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    digit_next = digit;
    case (state)
      ST_START: begin
        if (start_req) begin
          state_next = ST_COUNTDOWN;
          digit_next = 2'(COUNT_FROM);
        end
      end
      ST_COUNTDOWN: begin
        if (timer_done) begin
          if (digit == 2'd1) begin
            state_next = ST_PLAY;
            digit_next = 2'd0;
          end else begin
            digit_next = digit - 2'd1;
          end
        end
      end
      ST_PLAY: begin
        if (game_over_in) state_next = ST_END;
      end
      ST_END: begin
        if (timer_done) state_next = ST_START;
      end
      default: begin
        state_next = ST_START;
        digit_next = 2'd0;
      end
    endcase
  end

  always_comb begin
    pixel_next = start_pixel_in;
    case (state)
      ST_COUNTDOWN: pixel_next = half_rgb(game_pixel_in);
      ST_PLAY:      pixel_next = game_pixel_in;
      ST_END:       pixel_next = end_pixel_in;
      default:      pixel_next = start_pixel_in;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state   <= ST_START;
      digit   <= 2'd0;
      btn_q   <= 1'b0;
      pixel_q <= '0;
    end else begin
      state   <= state_next;
      digit   <= digit_next;
      btn_q   <= start_btn_in;
      pixel_q <= pixel_next;
    end
  end

  assign state_out       = state;
  assign countdown_out   = digit;
  assign game_active_out = (state == ST_PLAY);
  assign pixel_out       = pixel_q;

endmodule

// File: tb/tb_screen_sequencer.sv
// Directed self-checking bench for screen_sequencer with short countdown and end-hold timing.
module tb_screen_sequencer;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [10:0] hcount_in;
  logic [9:0]  vcount_in;
  logic        start_btn_in;
  logic [10:0] cursor_x_in;
  logic [9:0]  cursor_y_in;
  logic        click_in;
  logic        game_over_in;
  logic [23:0] start_pixel_in;
  logic [23:0] game_pixel_in;
  logic [23:0] end_pixel_in;
  logic [1:0]  state_out;
  logic [1:0]  countdown_out;
  logic        game_active_out;
  logic [23:0] pixel_out;

  int total = 0;
  int bad   = 0;

  screen_sequencer #(
    .FRAMES_PER_COUNT (2),
    .COUNT_FROM       (3),
    .END_HOLD_FRAMES  (4)
  ) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .hcount_in       (hcount_in),
    .vcount_in       (vcount_in),
    .start_btn_in    (start_btn_in),
    .cursor_x_in     (cursor_x_in),
    .cursor_y_in     (cursor_y_in),
    .click_in        (click_in),
    .game_over_in    (game_over_in),
    .start_pixel_in  (start_pixel_in),
    .game_pixel_in   (game_pixel_in),
    .end_pixel_in    (end_pixel_in),
    .state_out       (state_out),
    .countdown_out   (countdown_out),
    .game_active_out (game_active_out),
    .pixel_out       (pixel_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  // One cycle with the frame tick asserted, then back to a non-zero column.
  task automatic frame();
    hcount_in = 11'd0;
    vcount_in = 10'd0;
    step();
    hcount_in = 11'd1;
  endtask

  task automatic click_at(input int x, input int y);
    cursor_x_in = 11'(x);
    cursor_y_in = 10'(y);
    click_in    = 1'b1;
    step();
    click_in    = 1'b0;
    step();
  endtask

  initial begin
    int exp_digit [6] = '{3, 3, 2, 2, 1, 1};

    rst_in         = 1'b1;
    hcount_in      = 11'd1;
    vcount_in      = 10'd0;
    start_btn_in   = 1'b0;
    cursor_x_in    = 11'd0;
    cursor_y_in    = 10'd0;
    click_in       = 1'b0;
    game_over_in   = 1'b0;
    start_pixel_in = 24'h112233;
    game_pixel_in  = 24'h204080;
    end_pixel_in   = 24'hABCDEF;
    step();
    step();
    check("reset_state",  32'(state_out), 32'd0);
    check("reset_digit",  32'(countdown_out), 32'd0);
    check("reset_active", 32'(game_active_out), 32'd0);
    check("reset_pixel",  32'(pixel_out), 32'h0);

    rst_in = 1'b0;
    step();
    check("start_pixel", 32'(pixel_out), 32'h112233);

    // Held button: one transition only.
    start_btn_in = 1'b1;
    step();
    check("btn_to_countdown", 32'(state_out), 32'd1);
    check("btn_digit", 32'(countdown_out), 32'd3);
    for (int i = 0; i < 9; i++) step();
    check("btn_held_state", 32'(state_out), 32'd1);
    check("btn_held_digit", 32'(countdown_out), 32'd3);
    check("countdown_pixel", 32'(pixel_out), 32'h102040);
    check("countdown_inactive", 32'(game_active_out), 32'd0);
    start_btn_in = 1'b0;

    game_over_in = 1'b1;
    step();
    game_over_in = 1'b0;
    step();
    check("gameover_ignored_cd", 32'(state_out), 32'd1);

    for (int i = 0; i < 6; i++) begin
      check($sformatf("cd_digit_%0d", i), 32'(countdown_out), 32'(exp_digit[i]));
      check($sformatf("cd_state_%0d", i), 32'(state_out), 32'd1);
      frame();
    end
    check("play_state", 32'(state_out), 32'd2);
    check("play_active", 32'(game_active_out), 32'd1);
    check("play_digit", 32'(countdown_out), 32'd0);
    step();
    check("play_pixel", 32'(pixel_out), 32'h204080);

    game_over_in = 1'b1;
    step();
    game_over_in = 1'b0;
    check("end_state", 32'(state_out), 32'd3);
    check("end_inactive", 32'(game_active_out), 32'd0);
    step();
    check("end_pixel", 32'(pixel_out), 32'hABCDEF);

    start_btn_in = 1'b1;
    step();
    start_btn_in = 1'b0;
    step();
    check("start_ignored_end", 32'(state_out), 32'd3);
    for (int i = 0; i < 3; i++) frame();
    check("end_hold_3", 32'(state_out), 32'd3);
    frame();
    check("end_to_start", 32'(state_out), 32'd0);

    // Start request coinciding with a frame tick: that tick is not counted.
    start_btn_in = 1'b1;
    hcount_in    = 11'd0;
    vcount_in    = 10'd0;
    step();
    hcount_in    = 11'd1;
    start_btn_in = 1'b0;
    check("tick_start_state", 32'(state_out), 32'd1);
    check("tick_start_digit", 32'(countdown_out), 32'd3);
    for (int i = 0; i < 5; i++) frame();
    check("tick_start_5", 32'(state_out), 32'd1);
    check("tick_start_5_digit", 32'(countdown_out), 32'd1);

    // game_over asserted on the PLAY-entry cycle takes effect one cycle later.
    game_over_in = 1'b1;
    frame();
    check("entry_gameover_play", 32'(state_out), 32'd2);
    step();
    game_over_in = 1'b0;
    check("entry_gameover_end", 32'(state_out), 32'd3);

    for (int i = 0; i < 4; i++) frame();
    check("back_to_start", 32'(state_out), 32'd0);
    start_btn_in = 1'b1;
    step();
    start_btn_in = 1'b0;
    for (int i = 0; i < 6; i++) frame();
    step();
    check("pre_reset_play", 32'(state_out), 32'd2);

    rst_in = 1'b1;
    step();
    rst_in = 1'b0;
    check("midgame_rst_state",  32'(state_out), 32'd0);
    check("midgame_rst_active", 32'(game_active_out), 32'd0);
    check("midgame_rst_pixel",  32'(pixel_out), 32'h0);
    check("midgame_rst_digit",  32'(countdown_out), 32'd0);

`ifdef CURSOR_SELECT_EN
    click_at(379, 550);
    check("click_left_miss", 32'(state_out), 32'd0);
    click_at(580, 550);
    check("click_right_miss", 32'(state_out), 32'd0);
    cursor_x_in = 11'd380;
    cursor_y_in = 10'd500;
    click_in    = 1'b1;
    step();
    click_in    = 1'b0;
    check("click_hit", 32'(state_out), 32'd1);
`else
    click_at(380, 500);
    check("click_disabled", 32'(state_out), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/screen_sequencer.md
# screen_sequencer

Top-level screen controller that sequences the start screen, a pre-game countdown, live gameplay and a game-over hold. It sits between the per-screen renderers (start screen, game, end screen) and the video output. It decides which renderer drives the pixel stream, gates the game logic via `game_active_out`, and accepts a start request from a button or, optionally, a cursor click on the play button.

## Interface
Parameters:
- FRAMES_PER_COUNT, 60: frames per countdown digit.
- COUNT_FROM, 3: first countdown digit (1..3).
- END_HOLD_FRAMES, 180: frames spent in END before returning to START.
- BTN_X, 380; BTN_Y, 500: play button top-left corner in pixels.
- BTN_W, 200; BTN_H, 100: play button size in pixels.

Ports:
- clk_in  input  1  pixel clock; the only clock.
- rst_in  input  1  synchronous, active-high reset.
- hcount_in  input  11  current pixel column.
- vcount_in  input  10  current pixel row.
- start_btn_in  input  1  debounced start button, level.
- cursor_x_in  input  11  cursor column.
- cursor_y_in  input  10  cursor row.
- click_in  input  1  debounced click, level.
- game_over_in  input  1  game logic reports end of game, level.
- start_pixel_in  input  24  start-screen renderer RGB.
- game_pixel_in  input  24  game renderer RGB.
- end_pixel_in  input  24  end-screen renderer RGB.
- state_out  output  2  current state: START=0, COUNTDOWN=1, PLAY=2, END=3.
- countdown_out  output  2  digit currently shown; 0 outside COUNTDOWN.
- game_active_out  output  1  high only in PLAY.
- pixel_out  output  24  selected RGB, registered.

## Operation
- Frame tick: single-cycle `frame_tick = (hcount_in==0 && vcount_in==0)`.
- Start request: a rising edge of start_btn_in, detected against a registered copy. With CURSOR_SELECT_EN defined, a rising edge of click_in also counts, provided that in the same cycle `BTN_X <= cursor_x_in < BTN_X+BTN_W` and `BTN_Y <= cursor_y_in < BTN_Y+BTN_H`.
- START: pixel = start_pixel_in. On a start request, go to COUNTDOWN with digit=COUNT_FROM and frame counter=0.
- COUNTDOWN: pixel = game_pixel_in with each channel shifted right by 1 (half brightness).
  - The frame counter increments on each frame_tick.
  - When the counter reaches FRAMES_PER_COUNT-1 on a tick, it clears and the digit decrements.
  - When digit 1 expires, go to PLAY.
  - Start requests and game_over_in are ignored.
- PLAY: pixel = game_pixel_in; game_active_out=1. game_over_in high in any cycle moves to END with the counter cleared.
- END: pixel = end_pixel_in. The counter increments on frame_tick. After END_HOLD_FRAMES ticks, go to START. Start requests are ignored.
- Counter width: $clog2(max(FRAMES_PER_COUNT, END_HOLD_FRAMES)+1). The counter never wraps; it is cleared on every state entry.
- Simultaneous events:
  - A start request and a frame_tick in the same START cycle: the tick is not counted toward the first digit.
  - game_over_in in the same cycle as PLAY entry is honoured on the next cycle.
- Reset, including mid-game: next cycle state=START, counter=0, digit=0, edge registers=0, pixel_out=0.

## Timing
- Reset values: state_out=0, countdown_out=0, game_active_out=0, pixel_out=24'h0.
- State transitions take effect on the clock edge after the triggering cycle. state_out, countdown_out and game_active_out are driven directly from registers.
- pixel_out has 1-cycle latency: it is registered from the pixel inputs and the state value in effect during the input cycle.
- Start-request latency: rising edge at cycle N gives state_out=1 at N+1.
- Countdown length: exactly COUNT_FROM×FRAMES_PER_COUNT frame_ticks from COUNTDOWN entry to PLAY entry.

## Configuration
- CURSOR_SELECT_EN defined:
  - Cursor click on the play button rectangle is a start request.
  - cursor_x_in, cursor_y_in and click_in are used.
- CURSOR_SELECT_EN undefined:
  - Only start_btn_in starts the game.
  - The cursor ports remain present but unused; the hit-test logic is not compiled.

## Structure
- Shared package `screen_pkg`:
  - state enum `screen_state_t` (2-bit, values as above).
  - `rgb_t` (24-bit packed r/g/b).
  - Default play-button geometry constants, also used by start_display.
- One sub-module, `frame_timer`:
  - inputs: clk_in, rst_in, clear, tick, limit.
  - output: done pulse when count==limit-1 on a tick.
  - One instance serves both COUNTDOWN and END.

## Test plan
- Reset asserted mid-PLAY → next cycle state_out=0, game_active_out=0, pixel_out=0.
- In START, start_btn_in held high for 10 cycles → exactly one transition to state 1, countdown_out=3; held level causes no retrigger later.
- With FRAMES_PER_COUNT=2 and COUNT_FROM=3, issue 6 frame_ticks → countdown_out sequence 3,3,2,2,1,1, then state_out=2, game_active_out=1.
- In PLAY with game_pixel_in=24'h204080 → pixel_out=24'h204080 one cycle later. In COUNTDOWN the same input → 24'h102040.
- game_over_in pulse in PLAY → state 3. After END_HOLD_FRAMES=4 ticks → state 0. A start press during END is ignored.
- CURSOR_SELECT_EN: click at (379,550) → no start. Click at (380,500) → state 1. Click at (580,550) → no start.
